// File: rtl/floor_request_dispatcher.sv
// Serialises elevator call-button presses into single req_floor/weight requests,
// each shown as a value change and followed by a return-to-zero gap.
module floor_request_dispatcher #(
    parameter int FLOOR_W     = 3,
    parameter int WEIGHT_W    = 11,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**FLOOR_W-1:0] button,
    input  logic [WEIGHT_W-1:0]   load_weight,
    input  logic                  complete,
    input  logic [FLOOR_W-1:0]    out_floor,
    input  logic                  over_weight,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic [WEIGHT_W-1:0]   weight,
    output logic [2**FLOOR_W-1:0] lamp,
    output logic                  busy,
    output logic                  alarm,
    output logic [1:0]            dbg_state
);

    localparam int NF      = 2**FLOOR_W;
    localparam int IW      = FLOOR_W + 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [NF-1:0]       r_btn_q;
    logic [NF-1:0]       r_pending;
    logic [NF-1:0]       r_outstanding;
    logic [NF-1:0]       r_lamp;
    logic [FLOOR_W-1:0]  r_last;
    logic [FLOOR_W-1:0]  r_req;
    logic [WEIGHT_W-1:0] r_weight;
    logic                r_busy;
    logic                r_alarm;

    logic [NF-1:0]       w_rise;
    logic [NF-1:0]       w_clr;
    logic [NF-1:0]       w_sel_mask;
    logic [NF-1:0]       w_pend_nxt;
    logic [NF-1:0]       w_out_nxt;
    logic [FLOOR_W-1:0]  w_sel_floor;
    logic                w_issue;

    assign w_rise = button & ~r_btn_q & ~r_lamp & ~NF'(1);
    assign w_clr  = (complete && out_floor != '0) ? (NF'(1) << out_floor) : '0;

    // Round-robin: scan floors from last_issued+1 upward over 1..NF-1; the
    // reverse loop lets the nearest pending floor overwrite farther ones.
    always_comb begin
        logic [IW-1:0]      start_idx;
        logic [IW-1:0]      idx;
        logic [FLOOR_W-1:0] fl;
        w_sel_floor = '0;
        idx         = '0;
        fl          = '0;
        start_idx   = (r_last == FLOOR_W'(NF-1)) ? '0 : IW'(r_last);
        for (int k = NF-2; k >= 0; k--) begin
            idx = start_idx + IW'(k);
            if (idx >= IW'(NF-1)) idx = idx - IW'(NF-1);
            fl = FLOOR_W'(idx + IW'(1));
            if (r_pending[fl]) w_sel_floor = fl;
        end
    end

    assign w_issue    = (r_state == S_IDLE) && !r_alarm && (r_pending != '0);
    assign w_sel_mask = w_issue ? (NF'(1) << w_sel_floor) : '0;
    // Serve clear is applied last so it beats a same-cycle capture.
    assign w_pend_nxt = (r_pending | w_rise) & ~w_sel_mask & ~w_clr;
    assign w_out_nxt  = (r_outstanding | w_sel_mask) & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_btn_q       <= '0;
            r_pending     <= '0;
            r_outstanding <= '0;
            r_lamp        <= '0;
            r_last        <= '0;
            r_req         <= '0;
            r_weight      <= '0;
            r_busy        <= 1'b0;
            r_alarm       <= 1'b0;
        end else begin
            r_btn_q       <= button;
            r_alarm       <= over_weight;
            r_pending     <= w_pend_nxt;
            r_outstanding <= w_out_nxt;
            r_lamp        <= w_pend_nxt | w_out_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req    <= w_sel_floor;
                        r_weight <= load_weight;
                        r_last   <= w_sel_floor;
                        r_cnt    <= CW'(HOLD_CYCLES - 1);
                        r_state  <= S_DRIVE;
                        r_busy   <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == '0) begin
                        r_req   <= '0;
                        r_cnt   <= CW'(GAP_CYCLES - 1);
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= '0;
                end
            endcase
        end
    end

    assign req_floor = r_req;
    assign weight    = r_weight;
    assign lamp      = r_lamp;
    assign busy      = r_busy;
    assign alarm     = r_alarm;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Directed bench for floor_request_dispatcher: a vector table for the basic
// issue/serve cycle plus hand-written multi-cycle sequences.
module tb_floor_request_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [7:0]  button;
    logic [10:0] load_weight;
    logic        complete;
    logic [2:0]  out_floor;
    logic        over_weight;
    logic [2:0]  req_floor;
    logic [10:0] weight;
    logic [7:0]  lamp;
    logic        busy;
    logic        alarm;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    floor_request_dispatcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .load_weight(load_weight),
        .complete   (complete),
        .out_floor  (out_floor),
        .over_weight(over_weight),
        .req_floor  (req_floor),
        .weight     (weight),
        .lamp       (lamp),
        .busy       (busy),
        .alarm      (alarm),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  btn;
        logic [10:0] lw;
        logic        cmp;
        logic [2:0]  of;
        logic        ow;
        logic [2:0]  e_req;
        logic [10:0] e_w;
        logic [7:0]  e_lamp;
        logic        e_busy;
        logic        e_alarm;
    } vec_t;

    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] mask);
        button = mask;
        tick();
        button = '0;
    endtask

    task automatic serve(input logic [2:0] f);
        complete  = 1'b1;
        out_floor = f;
        tick();
        complete  = 1'b0;
        out_floor = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("idle_reached", busy, 0);
    endtask

    // Next request must appear only after req_floor has been seen at 0.
    task automatic wait_issue(input logic [10:0] exp_w);
        logic       seen_zero;
        logic       got;
        logic [2:0] exp_f;
        exp_f     = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        seen_zero = (req_floor == 3'd0);
        got       = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (req_floor == 3'd0) seen_zero = 1'b1;
            else if (seen_zero) got = 1'b1;
        end
        chk("issue_seen", got, 1);
        chk("issue_floor", req_floor, exp_f);
        chk("issue_weight", weight, exp_w);
    endtask

    initial begin
        int nz;
        rst_n = 1'b0; button = '0; load_weight = '0; complete = 1'b0;
        out_floor = '0; over_weight = 1'b0;

        //        btn    lw    cmp of ow   req w    lamp  busy alarm
        vt[0] = '{8'h20, 300,  0,  0, 0,   0,  0,   8'h20, 0, 0};
        vt[1] = '{8'h00, 300,  0,  0, 0,   5,  300, 8'h20, 1, 0};
        vt[2] = '{8'h20, 0,    0,  0, 0,   5,  300, 8'h20, 1, 0};
        vt[3] = '{8'h00, 0,    0,  0, 0,   0,  300, 8'h20, 1, 0};
        vt[4] = '{8'h00, 0,    0,  0, 0,   0,  300, 8'h20, 0, 0};
        vt[5] = '{8'h00, 0,    1,  5, 0,   0,  300, 8'h00, 0, 0};
        vt[6] = '{8'h00, 0,    0,  0, 0,   0,  300, 8'h00, 0, 0};
        vt[7] = '{8'h00, 0,    0,  0, 1,   0,  300, 8'h00, 0, 1};
        vt[8] = '{8'h00, 0,    0,  0, 0,   0,  300, 8'h00, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_req", req_floor, 0);
        chk("rst_weight", weight, 0);
        chk("rst_lamp", lamp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alarm", alarm, 0);
        rst_n = 1'b1;

        // Press 5, hold two cycles, gap, serve.
        for (int i = 0; i < 9; i++) begin
            button = vt[i].btn; load_weight = vt[i].lw; complete = vt[i].cmp;
            out_floor = vt[i].of; over_weight = vt[i].ow;
            tick();
            chk($sformatf("vec%0d_req", i), req_floor, vt[i].e_req);
            chk($sformatf("vec%0d_weight", i), weight, vt[i].e_w);
            chk($sformatf("vec%0d_lamp", i), lamp, vt[i].e_lamp);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d_alarm", i), alarm, vt[i].e_alarm);
        end
        button = '0; complete = 1'b0; out_floor = '0; over_weight = 1'b0;

        // Floor 4: issue, ignored re-press while outstanding, serve, re-issue.
        load_weight = 11'd150;
        press(8'h10);
        exp_q.push_back(3'd4);
        wait_issue(11'd150);
        press(8'h10);
        tick();
        chk("f4_outstanding_lamp", lamp, 8'h10);
        wait_idle();
        nz = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_floor != 3'd0) nz++;
        end
        chk("f4_no_reissue", nz, 0);
        serve(3'd4);
        chk("f4_served_lamp", lamp, 8'h00);
        press(8'h10);
        exp_q.push_back(3'd4);
        wait_issue(11'd150);
        wait_idle();
        serve(3'd4);
        chk("f4_second_served", lamp, 8'h00);

        // Floors 3,6,2 together after last_issued=4 -> 6, 2, 3.
        load_weight = 11'd77;
        press(8'h4C);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        wait_issue(11'd77);
        wait_issue(11'd77);
        wait_issue(11'd77);
        wait_idle();
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_floor != 3'd0) nz++;
        end
        chk("rr_no_reissue", nz, 0);
        chk("rr_lamp_outstanding", lamp, 8'h4C);
        serve(3'd6);
        serve(3'd2);
        serve(3'd3);
        chk("rr_lamp_served", lamp, 8'h00);

        // Overweight blocks issue of {2,7}; release resumes with 7 (last=3).
        load_weight = 11'd500;
        over_weight = 1'b1;
        tick();
        press(8'h84);
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_floor != 3'd0 || busy) nz++;
        end
        chk("ow_blocked", nz, 0);
        chk("ow_alarm", alarm, 1);
        chk("ow_lamp", lamp, 8'h84);
        over_weight = 1'b0;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        wait_issue(11'd500);
        chk("ow_alarm_clear", alarm, 0);
        wait_issue(11'd500);
        wait_idle();
        serve(3'd7);
        serve(3'd2);
        chk("ow_lamp_served", lamp, 8'h00);

        // Press 6 in the same cycle as its completion: clear wins.
        press(8'h40);
        exp_q.push_back(3'd6);
        wait_issue(11'd500);
        wait_idle();
        button = 8'h40; complete = 1'b1; out_floor = 3'd6;
        tick();
        button = '0; complete = 1'b0; out_floor = '0;
        chk("clr_wins_lamp", lamp, 8'h00);
        repeat (3) tick();
        chk("clr_wins_req", req_floor, 0);
        chk("clr_wins_busy", busy, 0);
        chk("clr_wins_lamp_late", lamp, 8'h00);

        // Asynchronous reset in the middle of a request for floor 5.
        press(8'h20);
        tick();
        chk("mid_drive_req", req_floor, 5);
        chk("mid_drive_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", req_floor, 0);
        chk("async_rst_lamp", lamp, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_weight", weight, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", req_floor, 0);
        chk("post_rst_lamp", lamp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
